// File: rtl/core_sequencer_if.sv
// Data-memory port bundle for core_sequencer: core and external requests in,
// muxed memory controls and the external grant out.
interface core_sequencer_if;
  logic       core_mem_wen;
  logic [7:0] core_addr;
  logic [7:0] core_wdat;
  logic       ext_req;
  logic       ext_we;
  logic [7:0] ext_addr;
  logic [7:0] ext_wdat;
  logic       ext_gnt;
  logic       dm_wen;
  logic [7:0] dm_addr;
  logic [7:0] dm_wdat;

  // Requesting side: core datapath plus external loader/checker.
  modport master (
    output core_mem_wen, core_addr, core_wdat,
    output ext_req, ext_we, ext_addr, ext_wdat,
    input  ext_gnt, dm_wen, dm_addr, dm_wdat
  );

  // Sequencer side: owns arbitration and the memory mux.
  modport slave (
    input  core_mem_wen, core_addr, core_wdat,
    input  ext_req, ext_we, ext_addr, ext_wdat,
    output ext_gnt, dm_wen, dm_addr, dm_wdat
  );
endinterface

// File: rtl/core_sequencer.sv
// Run controller for the 9-bit core: start/done handshake, core reset and
// enable, halt/end-of-program detection, watchdog, and data-memory arbitration.
module core_sequencer #(
  parameter int unsigned             PC_W       = 8,
  parameter int unsigned             CNT_W      = 16,
  parameter logic [PC_W-1:0]         LAST_PC    = 8'hFF,
  parameter logic [CNT_W-1:0]        MAX_CYCLES = 16'hFFFF,
  parameter int unsigned             CLR_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    pc,
  input  logic               halt_insn,
  core_sequencer_if.slave    bus,
  output logic               core_rst,
  output logic               core_en,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST  = MAX_CYCLES - 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic             start_q;
  logic [CLR_W-1:0] clr_cnt;
  logic             start_edge;
  logic             ext_own;

  assign start_edge = start & ~start_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      start_q     <= 1'b1;
      clr_cnt     <= '0;
      core_rst    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      start_q <= start;
      unique case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            state       <= CLEAR;
            clr_cnt     <= CLR_LOAD;
            core_rst    <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
          end
        end
        CLEAR: begin
          if (clr_cnt == '0) begin
            state    <= RUN;
            core_rst <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt - 1'b1;
          end
        end
        RUN: begin
          cycle_count <= cycle_count + 1'b1;
          // Halt / end-of-program take priority so a simultaneous watchdog hit
          // does not flag a timeout.
          if (halt_insn || (pc == LAST_PC)) begin
            state <= DRAIN;
          end else if (cycle_count == WD_LAST) begin
            state   <= DRAIN;
            timeout <= 1'b1;
          end
        end
        DRAIN: begin
          state    <= DONE;
          busy     <= 1'b0;
          done     <= 1'b1;
          core_rst <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          core_rst <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // External side owns the memory only while the core is parked.
  always_comb begin
    ext_own     = (state == IDLE) || (state == DONE);
    core_en     = (state == RUN) && !halt_insn;
    bus.ext_gnt = ext_own && bus.ext_req;
    if (ext_own) begin
      bus.dm_wen  = bus.ext_gnt && bus.ext_we;
      bus.dm_addr = bus.ext_addr;
      bus.dm_wdat = bus.ext_wdat;
    end else begin
      bus.dm_wen  = bus.core_mem_wen && core_en;
      bus.dm_addr = bus.core_addr;
      bus.dm_wdat = bus.core_wdat;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: mux vector table plus run-sequence checks.
module tb_core_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] pc;
  logic       halt_insn;
  logic       core_rst;
  logic       core_en;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [15:0] cycle_count;

  int unsigned total;
  int unsigned bad;

  core_sequencer_if bus ();

  core_sequencer #(
    .PC_W       (8),
    .CNT_W      (16),
    .LAST_PC    (8'hFF),
    .MAX_CYCLES (16'd10),
    .CLR_CYCLES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pc          (pc),
    .halt_insn   (halt_insn),
    .bus         (bus),
    .core_rst    (core_rst),
    .core_en     (core_en),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    logic       in_run;
    logic       req;
    logic       we;
    logic [7:0] eaddr;
    logic [7:0] ewdat;
    logic       cwen;
    logic [7:0] caddr;
    logic [7:0] cwdat;
    logic       x_gnt;
    logic       x_wen;
    logic       x_en;
    logic [7:0] x_addr;
    logic [7:0] x_wdat;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_table(input logic run_phase);
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].in_run == run_phase) begin
        bus.ext_req      = vecs[i].req;
        bus.ext_we       = vecs[i].we;
        bus.ext_addr     = vecs[i].eaddr;
        bus.ext_wdat     = vecs[i].ewdat;
        bus.core_mem_wen = vecs[i].cwen;
        bus.core_addr    = vecs[i].caddr;
        bus.core_wdat    = vecs[i].cwdat;
        #1;
        check($sformatf("vec%0d_gnt", i),  32'(bus.ext_gnt), 32'(vecs[i].x_gnt));
        check($sformatf("vec%0d_wen", i),  32'(bus.dm_wen),  32'(vecs[i].x_wen));
        check($sformatf("vec%0d_en", i),   32'(core_en),     32'(vecs[i].x_en));
        check($sformatf("vec%0d_addr", i), 32'(bus.dm_addr), 32'(vecs[i].x_addr));
        check($sformatf("vec%0d_wdat", i), 32'(bus.dm_wdat), 32'(vecs[i].x_wdat));
      end
    end
    bus.ext_req      = 1'b0;
    bus.ext_we       = 1'b0;
    bus.core_mem_wen = 1'b0;
  endtask

  // Start edge, two CLEAR cycles, return positioned in RUN cycle 1.
  task automatic launch(input string tag);
    halt_insn = 1'b0;
    pc        = 8'h00;
    start     = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check({tag, "_clr1_rst"},   32'(core_rst),    32'd1);
    check({tag, "_clr1_busy"},  32'(busy),        32'd1);
    check({tag, "_clr1_count"}, 32'(cycle_count), 32'd0);
    check({tag, "_clr1_tmo"},   32'(timeout),     32'd0);
    tick();
    check({tag, "_clr2_rst"},   32'(core_rst),    32'd1);
    tick();
    check({tag, "_run1_rst"},   32'(core_rst),    32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //          run req we eaddr  ewdat cwen caddr  cwdat gnt wen en  addr   wdat
    vecs[0] = '{1'b0, 1, 1, 8'h20, 8'hA5, 1, 8'h33, 8'h44, 1, 1, 0, 8'h20, 8'hA5};
    vecs[1] = '{1'b0, 1, 0, 8'h21, 8'h5A, 1, 8'h33, 8'h44, 1, 0, 0, 8'h21, 8'h5A};
    vecs[2] = '{1'b0, 0, 1, 8'h22, 8'h77, 1, 8'h33, 8'h44, 0, 0, 0, 8'h22, 8'h77};
    vecs[3] = '{1'b1, 1, 1, 8'h20, 8'hA5, 1, 8'h40, 8'h99, 0, 1, 1, 8'h40, 8'h99};
    vecs[4] = '{1'b1, 1, 1, 8'h20, 8'hA5, 0, 8'h41, 8'h98, 0, 0, 1, 8'h41, 8'h98};
    vecs[5] = '{1'b1, 0, 0, 8'h23, 8'h11, 1, 8'h42, 8'h97, 0, 1, 1, 8'h42, 8'h97};

    reset = 1'b0;
    start = 1'b0;
    pc = 8'h00;
    halt_insn = 1'b0;
    bus.core_mem_wen = 1'b0;
    bus.core_addr = 8'h00;
    bus.core_wdat = 8'h00;
    bus.ext_req = 1'b0;
    bus.ext_we = 1'b0;
    bus.ext_addr = 8'h5C;
    bus.ext_wdat = 8'hC3;
    tick();
    tick();
    check("rst_core_rst", 32'(core_rst),    32'd1);
    check("rst_core_en",  32'(core_en),     32'd0);
    check("rst_busy",     32'(busy),        32'd0);
    check("rst_done",     32'(done),        32'd0);
    check("rst_timeout",  32'(timeout),     32'd0);
    check("rst_count",    32'(cycle_count), 32'd0);
    check("rst_gnt",      32'(bus.ext_gnt), 32'd0);
    check("rst_wen",      32'(bus.dm_wen),  32'd0);
    check("rst_addr",     32'(bus.dm_addr), 32'h5C);
    check("rst_wdat",     32'(bus.dm_wdat), 32'hC3);
    reset = 1'b1;
    tick();
    apply_table(1'b0);

    // Halt on RUN cycle 5; store on cycle 4 commits, store on cycle 5 and in DRAIN does not.
    launch("halt");
    apply_table(1'b1);
    for (int k = 1; k <= 5; k++) begin
      halt_insn        = (k == 5);
      bus.core_mem_wen = (k >= 4);
      pc               = 8'(k);
      #1;
      check($sformatf("halt_c%0d_en", k),  32'(core_en),    32'(k != 5));
      check($sformatf("halt_c%0d_wen", k), 32'(bus.dm_wen), 32'(k == 4));
      tick();
    end
    halt_insn = 1'b0;
    #1;
    check("halt_drain_en",    32'(core_en),     32'd0);
    check("halt_drain_wen",   32'(bus.dm_wen),  32'd0);
    check("halt_drain_busy",  32'(busy),        32'd1);
    check("halt_drain_done",  32'(done),        32'd0);
    check("halt_drain_rst",   32'(core_rst),    32'd0);
    bus.core_mem_wen = 1'b0;
    tick();
    check("halt_done",        32'(done),        32'd1);
    check("halt_done_busy",   32'(busy),        32'd0);
    check("halt_done_rst",    32'(core_rst),    32'd1);
    check("halt_count",       32'(cycle_count), 32'd5);
    check("halt_timeout",     32'(timeout),     32'd0);

    // start still high: stays in DONE; external owns memory.
    tick();
    tick();
    tick();
    bus.ext_req = 1'b1;
    bus.ext_we  = 1'b1;
    #1;
    check("hold_done",        32'(done),        32'd1);
    check("hold_count",       32'(cycle_count), 32'd5);
    check("hold_gnt",         32'(bus.ext_gnt), 32'd1);
    check("hold_wen",         32'(bus.dm_wen),  32'd1);
    bus.ext_req = 1'b0;
    bus.ext_we  = 1'b0;

    // Watchdog: never halt, exit after RUN cycle 10.
    launch("wd");
    for (int k = 1; k <= 10; k++) begin
      pc = 8'(k);
      #1;
      check($sformatf("wd_c%0d_en", k), 32'(core_en), 32'd1);
      tick();
    end
    check("wd_drain_busy",  32'(busy),        32'd1);
    check("wd_drain_en",    32'(core_en),     32'd0);
    check("wd_timeout",     32'(timeout),     32'd1);
    check("wd_count",       32'(cycle_count), 32'd10);
    tick();
    check("wd_done",        32'(done),        32'd1);
    check("wd_done_tmo",    32'(timeout),     32'd1);

    // Halt coinciding with the watchdog cycle: halt wins.
    launch("hw");
    for (int k = 1; k <= 10; k++) begin
      halt_insn = (k == 10);
      pc        = 8'(k);
      tick();
    end
    halt_insn = 1'b0;
    check("hw_timeout",     32'(timeout),     32'd0);
    check("hw_count",       32'(cycle_count), 32'd10);
    tick();
    check("hw_done",        32'(done),        32'd1);

    // End-of-program PC: last instruction still executes.
    launch("lp");
    pc = 8'hFE;
    #1;
    check("lp_c1_en",       32'(core_en),     32'd1);
    tick();
    pc = 8'hFF;
    #1;
    check("lp_c2_en",       32'(core_en),     32'd1);
    tick();
    pc = 8'h00;
    check("lp_drain_busy",  32'(busy),        32'd1);
    check("lp_count",       32'(cycle_count), 32'd2);
    check("lp_timeout",     32'(timeout),     32'd0);
    tick();
    check("lp_done",        32'(done),        32'd1);

    // Start edge inside RUN is ignored, then a one-cycle reset mid-run.
    launch("rr");
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check("rr_run_busy",    32'(busy),        32'd1);
    check("rr_run_en",      32'(core_en),     32'd1);
    check("rr_run_count",   32'(cycle_count), 32'd2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rr_idle_busy",   32'(busy),        32'd0);
    check("rr_idle_rst",    32'(core_rst),    32'd1);
    check("rr_idle_done",   32'(done),        32'd0);
    check("rr_idle_en",     32'(core_en),     32'd0);
    tick();
    tick();
    check("rr_nostart",     32'(busy),        32'd0);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check("rr_restart",     32'(busy),        32'd1);
    check("rr_restart_rst", 32'(core_rst),    32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Run controller for the single-cycle 9-bit core: turns the external `start`/`done` handshake into a clean run sequence. It holds the core in reset, releases it, gates PC advance, detects halt, counts run cycles with a watchdog, and arbitrates the data-memory port between the core and an external loader/checker. It sits between the top-level `start`/`done` pins and the program counter, register file and data memory.

## Interface
- `PC_W`, 8: program counter width.
- `CNT_W`, 16: run-cycle counter width.
- `LAST_PC`, 8'hFF: PC value treated as end of program.
- `MAX_CYCLES`, 16'hFFFF: watchdog limit on RUN cycles, 1..2^CNT_W-1.
- `CLR_CYCLES`, 2: cycles `core_rst` is held in CLEAR, ≥1.

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-low.
- `start` in 1: run request; only its rising edge is used.
- `pc` in PC_W: current core PC.
- `halt_insn` in 1: control unit decodes the current instruction as halt.
- `core_mem_wen` in 1: core store enable.
- `core_addr`, `core_wdat` in 8: core memory address and write data.
- `ext_req` in 1: external memory access request.
- `ext_we` in 1: external write enable.
- `ext_addr`, `ext_wdat` in 8: external address and write data.
- `core_rst` out 1: active-high reset to PC and register file.
- `core_en` out 1: PC advance / register-write enable.
- `dm_wen` out 1: data-memory write enable.
- `dm_addr`, `dm_wdat` out 8: muxed memory address and write data.
- `ext_gnt` out 1: external access granted this cycle.
- `busy` out 1: high in CLEAR, RUN and DRAIN.
- `done` out 1: high in DONE.
- `timeout` out 1: last run ended on the watchdog.
- `cycle_count` out CNT_W: RUN cycles in the current or last run.

## Operation
- `start_q` registers `start`. A start edge is `start & ~start_q`. `start_q` resets to 1, so a `start` held high through reset does not launch a run.
- State IDLE (reset state): a start edge goes to CLEAR.
- State CLEAR:
  - `core_rst`=1, `core_en`=0.
  - `cycle_count`←0 and `timeout`←0 on entry.
  - Internal counter runs CLR_CYCLES cycles, then goes to RUN.
- State RUN:
  - `core_en` = ~`halt_insn`.
  - `cycle_count` increments every RUN cycle.
  - Exit to DRAIN when `halt_insn`=1 or `pc`==LAST_PC. The last instruction still executes unless it is a halt.
  - Exit to DRAIN with `timeout`←1 when `cycle_count`==MAX_CYCLES-1; this checks the pre-increment value.
  - If a halt and the watchdog hit in the same cycle, halt wins and `timeout` stays 0.
- State DRAIN: one cycle, `core_en`=0 and `dm_wen`=0, so no commits. Then go to DONE.
- State DONE:
  - `done`=1; `cycle_count` and `timeout` hold.
  - A start edge goes to CLEAR (restart).
  - `start` merely staying high has no effect.
- Arbitration:
  - The core owns memory in CLEAR, RUN and DRAIN.
  - External owns memory in IDLE and DONE: `ext_gnt` = `ext_req`.
  - `ext_gnt`=0 elsewhere; `ext_req` is then ignored, not queued.
- Memory mux:
  - `dm_addr` and `dm_wdat` follow the owner.
  - `dm_wen` = `ext_gnt & ext_we` for external ownership.
  - `dm_wen` = `core_mem_wen & core_en` for core ownership.
  - `dm_wen` is never high in CLEAR or DRAIN.
- `cycle_count` never wraps: the watchdog stops RUN first.
- A start edge in CLEAR, RUN or DRAIN is ignored.

## Timing
- Reset values:
  - state IDLE, `start_q`=1.
  - `core_rst`=1 (the core stays reset while idle).
  - `core_en`=0, `done`=0, `busy`=0, `timeout`=0, `cycle_count`=0, `ext_gnt`=0, `dm_wen`=0.
  - `dm_addr`=`ext_addr` and `dm_wdat`=`ext_wdat` (IDLE routes external).
- `core_rst`=1 in IDLE, CLEAR and DONE; 0 in RUN and DRAIN.
- All outputs are decoded from registered state. `core_en`, `ext_gnt` and the `dm_*` signals are combinational from state and inputs; everything else is registered.
- Start edge at cycle t: CLEAR occupies t+1..t+CLR_CYCLES, RUN begins at t+CLR_CYCLES+1.
- RUN exit sampled at cycle r: DRAIN at r+1, `done`=1 from r+2.
- Run latency with N RUN cycles: start edge to `done` = CLR_CYCLES+N+2 cycles; `cycle_count`=N.
- `reset` low in any state returns to IDLE on the next edge and discards the run; the core is re-reset by `core_rst`.

## Test plan
- Reset, then `start` rising, CLR_CYCLES=2, `halt_insn` asserted on the 5th RUN cycle:
  - `core_rst` high for 2 cycles after the edge;
  - `done` 2 cycles after the halt;
  - `cycle_count`=5, `timeout`=0, PC frozen on the halt cycle.
- MAX_CYCLES=10, never halt: exit after the 10th RUN cycle, `timeout`=1, `cycle_count`=10, `done` asserted; `halt_insn` on cycle 10 instead gives `timeout`=0.
- External write in IDLE, `ext_req`=`ext_we`=1, addr 8'h20, data 8'hA5:
  - `ext_gnt`=1 and `dm_wen`=1 with that addr and data.
  - Same request during RUN gives `ext_gnt`=0, `dm_wen` equal to `core_mem_wen`.
- `core_mem_wen`=1 on the halt cycle and during DRAIN: `dm_wen`=0 in both; a store on the cycle before the halt commits.
- `start` held high through DONE leaves the block in DONE; toggling `start` low then high restarts, and `cycle_count` and `timeout` clear in CLEAR.
- `reset` driven low mid-RUN for 1 cycle: next cycle IDLE, `busy`=0, `core_rst`=1, `done`=0; a `start` held high does not restart until it toggles.
